// File: rtl/ws2812b_tx_encoder.sv
// rtl/ws2812b_tx_encoder.sv - byte stream to WS2812B NRZ pulse-width serial encoder
//
// Purpose: accepts bytes over a valid/ready handshake into a one-byte holding
// register and serialises them MSB-first as WS2812B pulse-width bits on dout.
// After a byte flagged last, dout is held low for RESET_CYCLES (strip latch).
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   in_valid  byte offered
//   in_data   byte to send (colour order chosen by caller)
//   in_last   byte ends a frame; latch period follows it
//   in_ready  holding register empty (combinational)
//   dout      registered serial output
//   busy      high whenever the encoder is not idle
//   underrun  one-cycle pulse when a non-last byte ends with nothing buffered
module ws2812b_tx_encoder #(
  parameter int unsigned T0H          = 26,
  parameter int unsigned T1H          = 51,
  parameter int unsigned T_BIT        = 80,
  parameter int unsigned RESET_CYCLES = 3840
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       dout,
  output logic       busy,
  output logic       underrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BIT   = 2'd1,
    S_LATCH = 2'd2
  } state_e;

  localparam logic [15:0] TBIT_M1  = 16'(T_BIT - 1);
  localparam logic [15:0] TH0      = 16'(T0H);
  localparam logic [15:0] TH1      = 16'(T1H);
  localparam logic [15:0] LATCH_M1 = 16'(RESET_CYCLES - 1);

  state_e      state_q;
  logic        hold_valid_q;
  logic [7:0]  hold_data_q;
  logic        hold_last_q;
  logic [7:0]  sh_q;
  logic        sh_last_q;
  logic [2:0]  bit_cnt_q;
  logic [15:0] cyc_cnt_q;
  logic        dout_q;
  logic        underrun_q;

  logic        accept;
  logic        cyc_end;
  logic [15:0] cyc_nxt;
  logic [15:0] th_cur;

  assign in_ready = !hold_valid_q;
  // accept needs an empty hold and transfer needs a full one, so they can
  // never coincide on the same edge
  assign accept   = in_valid && !hold_valid_q;
  assign cyc_end  = (cyc_cnt_q == TBIT_M1);
  assign cyc_nxt  = cyc_cnt_q + 16'd1;
  assign th_cur   = sh_q[7] ? TH1 : TH0;

  assign dout     = dout_q;
  assign busy     = (state_q != S_IDLE);
  assign underrun = underrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'd0;
      hold_last_q  <= 1'b0;
      sh_q         <= 8'd0;
      sh_last_q    <= 1'b0;
      bit_cnt_q    <= 3'd0;
      cyc_cnt_q    <= 16'd0;
      dout_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      underrun_q <= 1'b0;

      if (accept) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= in_data;
        hold_last_q  <= in_last;
      end

      case (state_q)
        S_IDLE: begin
          dout_q <= 1'b0;
          if (hold_valid_q) begin
            sh_q         <= hold_data_q;
            sh_last_q    <= hold_last_q;
            hold_valid_q <= 1'b0;
            bit_cnt_q    <= 3'd0;
            cyc_cnt_q    <= 16'd0;
            dout_q       <= 1'b1;
            state_q      <= S_BIT;
          end
        end

        S_BIT: begin
          if (!cyc_end) begin
            // dout is registered, so decide the level of the coming cycle
            cyc_cnt_q <= cyc_nxt;
            dout_q    <= (cyc_nxt < th_cur);
          end else begin
            cyc_cnt_q <= 16'd0;
            if (bit_cnt_q != 3'd7) begin
              sh_q      <= {sh_q[6:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              dout_q    <= 1'b1;
            end else if (sh_last_q) begin
              bit_cnt_q <= 3'd0;
              dout_q    <= 1'b0;
              state_q   <= S_LATCH;
            end else if (hold_valid_q) begin
              // gapless chaining: next byte's first bit starts next cycle
              sh_q         <= hold_data_q;
              sh_last_q    <= hold_last_q;
              hold_valid_q <= 1'b0;
              bit_cnt_q    <= 3'd0;
              dout_q       <= 1'b1;
            end else begin
              bit_cnt_q  <= 3'd0;
              dout_q     <= 1'b0;
              underrun_q <= 1'b1;
              state_q    <= S_IDLE;
            end
          end
        end

        S_LATCH: begin
          // bytes may land in hold here; IDLE picks them up afterwards
          dout_q <= 1'b0;
          if (cyc_cnt_q == LATCH_M1) begin
            cyc_cnt_q <= 16'd0;
            state_q   <= S_IDLE;
          end else begin
            cyc_cnt_q <= cyc_nxt;
          end
        end

        default: begin
          dout_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_tx_encoder.sv
// tb/tb_ws2812b_tx_encoder.sv - self-checking bench for ws2812b_tx_encoder
module tb_ws2812b_tx_encoder;

  localparam int T0H          = 26;
  localparam int T1H          = 51;
  localparam int T_BIT        = 80;
  localparam int RESET_CYCLES = 3840;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       dout;
  logic       busy;
  logic       underrun;

  int n_assert = 0;
  int n_fail   = 0;

  // expected per-cycle waveform, one entry per negedge sample
  bit         ex_d[$];
  bit         ex_b[$];
  bit         ex_u[$];
  // stimulus: byte, last flag, earliest sample index at which it is offered
  logic [7:0] st_data[$];
  bit         st_last[$];
  int         st_rel[$];
  int         rdy_at;
  bit         rdy_exp;

  ws2812b_tx_encoder #(
    .T0H(T0H), .T1H(T1H), .T_BIT(T_BIT), .RESET_CYCLES(RESET_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .dout(dout), .busy(busy),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void push(bit d, bit b, bit u, int n);
    for (int i = 0; i < n; i++) begin
      ex_d.push_back(d);
      ex_b.push_back(b);
      ex_u.push_back(u);
    end
  endfunction

  // a WS2812B byte: eight periods of T_BIT, high for T1H on '1', T0H on '0'
  function automatic void push_byte(logic [7:0] v);
    int th;
    for (int i = 7; i >= 0; i--) begin
      th = v[i] ? T1H : T0H;
      push(1'b1, 1'b1, 1'b0, th);
      push(1'b0, 1'b1, 1'b0, T_BIT - th);
    end
  endfunction

  function automatic void push_latch();
    push(1'b0, 1'b1, 1'b0, RESET_CYCLES);
  endfunction

  function automatic void push_idle(int n);
    push(1'b0, 1'b0, 1'b0, n);
  endfunction

  function automatic void offer(logic [7:0] d, bit l, int rel);
    st_data.push_back(d);
    st_last.push_back(l);
    st_rel.push_back(rel);
  endfunction

  function automatic void clear_all();
    ex_d.delete(); ex_b.delete(); ex_u.delete();
    st_data.delete(); st_last.delete(); st_rel.delete();
    rdy_at = -1;
    rdy_exp = 1'b0;
  endfunction

  // Runs the stimulus and compares dout/busy/underrun against the expected
  // waveform, for limit samples (or the whole waveform when limit < 0).
  task automatic run(input string name, input int limit);
    int n, idx, nd, nb, nu, fd, fb, fu;
    bit pend;
    n = (limit >= 0 && limit < ex_d.size()) ? limit : ex_d.size();
    idx = 0; pend = 1'b0;
    nd = 0; nb = 0; nu = 0; fd = -1; fb = -1; fu = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (dout !== ex_d[k]) begin nd++; if (fd < 0) fd = k; end
      if (busy !== ex_b[k]) begin nb++; if (fb < 0) fb = k; end
      if (underrun !== ex_u[k]) begin nu++; if (fu < 0) fu = k; end
      if (k == rdy_at) chk($sformatf("%s in_ready@%0d", name, k), 32'(in_ready), 32'(rdy_exp));
      if (pend) begin idx++; pend = 1'b0; end
      if (idx < st_data.size() && k >= st_rel[idx]) begin
        in_valid = 1'b1;
        in_data  = st_data[idx];
        in_last  = st_last[idx];
      end else begin
        in_valid = 1'b0;
      end
      pend = in_valid && in_ready;
    end
    in_valid = 1'b0;
    chk($sformatf("%s dout mismatches (first %0d)", name, fd), nd, 0);
    chk($sformatf("%s busy mismatches (first %0d)", name, fb), nb, 0);
    chk($sformatf("%s underrun mismatches (first %0d)", name, fu), nu, 0);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, " dout"}, 32'(dout), 0);
    chk({name, " busy"}, 32'(busy), 0);
    chk({name, " underrun"}, 32'(underrun), 0);
    chk({name, " in_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    int nbytes, off, rel;
    logic [7:0] b0, b1, v;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
    rdy_at = -1; rdy_exp = 1'b0;
    #12;
    check_reset_state("reset");
    @(negedge clk); rst_n = 1'b1;

    // single byte 0xA5 with latch
    clear_all();
    offer(8'hA5, 1'b1, 0);
    push_idle(2); push_byte(8'hA5); push_latch(); push_idle(2);
    run("a5_frame", -1);

    // three bytes back to back, hold full while the first is shifting
    clear_all();
    offer(8'h12, 1'b0, 0); offer(8'h34, 1'b0, 0); offer(8'h56, 1'b1, 0);
    push_idle(2); push_byte(8'h12); push_byte(8'h34); push_byte(8'h56);
    push_latch(); push_idle(2);
    rdy_at = 100; rdy_exp = 1'b0;
    run("three_bytes", -1);

    // non-last byte with no successor: underrun, no latch
    clear_all();
    offer(8'hFF, 1'b0, 0);
    push_idle(2); push_byte(8'hFF); push(1'b0, 1'b0, 1'b1, 1); push_idle(4);
    run("underrun", -1);

    // byte offered mid-latch waits for IDLE
    clear_all();
    b0 = 8'($urandom); b1 = 8'($urandom);
    rel = 2 + 8 * T_BIT + 1000;
    offer(b0, 1'b1, 0); offer(b1, 1'b1, rel);
    push_idle(2); push_byte(b0); push_latch(); push_idle(1);
    push_byte(b1); push_latch(); push_idle(2);
    rdy_at = rel + 1; rdy_exp = 1'b0;
    run("mid_latch_offer", -1);

    // reset during the high phase of a bit
    clear_all();
    offer(8'h80, 1'b1, 0);
    push_idle(2); push_byte(8'h80); push_latch();
    run("pre_reset_bit", 12);
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_mid_bit");
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    chk("in_ready after release", 32'(in_ready), 1);

    // reset during LATCH, then a normal byte
    clear_all();
    offer(8'h3C, 1'b1, 0);
    push_idle(2); push_byte(8'h3C); push_latch();
    run("pre_reset_latch", 2 + 8 * T_BIT + 100);
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_mid_latch");
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    clear_all();
    offer(8'hC3, 1'b1, 0);
    push_idle(2); push_byte(8'hC3); push_latch(); push_idle(2);
    run("after_reset", -1);

    // random frames
    for (int f = 0; f < 3; f++) begin
      clear_all();
      nbytes = $urandom_range(1, 3);
      off = $urandom_range(0, 5);
      push_idle(off + 2);
      for (int i = 0; i < nbytes; i++) begin
        v = 8'($urandom);
        offer(v, (i == nbytes - 1), (i == 0) ? off : 0);
        push_byte(v);
      end
      push_latch(); push_idle(2);
      run($sformatf("random_frame%0d", f), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812b_tx_encoder.md
Name: ws2812b_tx_encoder

Overview:
- Upstream companion to the impostor WS2812B receiver peripheral.
- Takes a byte stream over a valid/ready handshake and serialises it MSB-first into WS2812B NRZ pulse-width waveform on a single pin.
- Emits the reset/latch low period after a frame's last byte.
- Used to drive real LED strips and to feed the receiver in loopback tests; one byte of buffering gives gapless back-to-back bytes.

Parameters:
- T0H, 26, high time of a '0' bit in clk cycles (0.4 us at 64 MHz)
- T1H, 51, high time of a '1' bit in clk cycles (0.8 us at 64 MHz)
- T_BIT, 80, total bit period in clk cycles (1.25 us at 64 MHz)
- RESET_CYCLES, 3840, latch low time after the last byte (60 us at 64 MHz)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  byte offered
- in_data  input  8  byte to send (G, R, B order is caller's responsibility)
- in_last  input  1  byte is final of frame; latch follows it
- in_ready  output  1  holding register empty; byte accepted when in_valid && in_ready at clk edge
- dout  output  1  registered WS2812B serial output
- busy  output  1  high whenever state != IDLE
- underrun  output  1  one-cycle pulse: non-last byte finished with no successor buffered

Behaviour:
- Reset: asynchronous, active-low; rst_n low forces the following immediately and independent of clk: dout=0, busy=0, underrun=0, hold empty (in_ready=1), state=IDLE, all counters 0. Applies mid-bit, mid-latch, anywhere.
- Static constraints: 1 <= T0H < T1H < T_BIT. RESET_CYCLES <= 65535. Internal cycle counter is 16 bit; bit counter is 3 bit.
- Holding register: hold_valid, hold_data, hold_last.
  - in_ready = !hold_valid, combinational.
  - Accept sets hold_valid. Transfer to the shifter clears it on the same edge. No accept and transfer on the same edge.
- FSM states:
  - IDLE: dout=0. If hold_valid: load shifter (data, last), bit_cnt=0, cyc_cnt=0, dout<=1, go BIT. Latency: dout rises on the edge after the accepting edge.
  - BIT: cyc_cnt counts 0..T_BIT-1. dout is 1 for cycles 0..TH-1 and 0 for TH..T_BIT-1, where TH = T1H if the current MSB is 1, else T0H. Each bit period is exactly T_BIT cycles. On cyc_cnt==T_BIT-1: shift left, bit_cnt++, cyc_cnt=0.
  - Byte end: the last cycle of bit_cnt==7 takes the first matching case below.
    - sh_last=1: go LATCH, dout stays 0.
    - hold_valid: load next byte, stay BIT. Next bit period starts on the next cycle, so there is zero gap.
    - Otherwise: go IDLE, pulse underrun for 1 cycle. No latch.
  - LATCH: dout=0 for exactly RESET_CYCLES cycles, counted from the end of the last bit period, then IDLE. Bytes may be accepted into hold during LATCH; they are sent only after returning to IDLE.
- busy = (state != IDLE); it is 0 in the cycle IDLE is re-entered.
- in_valid while in_ready=0: ignored. The caller holds data stable; no overwrite.
- in_last on a byte accepted while the current byte is non-last: honoured only when that byte itself ends.

Test Plan:
- Single byte 0xA5, in_last=1, defaults -> dout high times 51,26,51,26,26,51,26,51 in 80-cycle periods. Then 3840 low cycles. busy high for exactly 640+3840 cycles; underrun never pulses.
- Three bytes 0x12,0x34,0x56 with in_valid held, last on 0x56 -> 1920 contiguous bit-period cycles with no gap. in_ready low while hold is full. Latch follows.
- One byte 0xFF, in_last=0, no successor -> after 640 cycles underrun=1 for one cycle, busy=0, dout=0, no 3840-cycle latch.
- rst_n low during a bit's high phase and during LATCH -> dout=0 and busy=0 immediately, without a clock. After release, in_ready=1 and a new byte transmits normally.
- Byte offered mid-LATCH -> accepted (in_ready drops). Its first rising edge occurs 1 cycle after LATCH ends, not earlier.
- Loopback: dout into the impostor_ws2812b receiver (threshold 38, idle 3840), frame 0x10,0x20,0x30 -> receiver reads G=0x10, R=0x20, B=0x30 and rgb_ready sets.
